// File: rtl/sender_multibit.sv
// Multi-bit covert-channel sender: each BPS-bit symbol is sent as sym*BLK_PER_LVL
// cache-line loads per window. Optional parity sync windows: define SENDER_PARITY_EN.
module sender_multibit #(
  parameter int STR_LEN      = 64,
  parameter int LOG_STR_LEN  = 6,
  parameter int BPS          = 2,
  parameter int BLK_PER_LVL  = 4,
  parameter int TAG_LEN      = 8,
  parameter int COUNTER_SIZE = 16,
  parameter int ECI_W        = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    input_ready,
  input  logic [STR_LEN-1:0]      string_i,   // "string" is a reserved word
  input  logic [LOG_STR_LEN-1:0]  eos,
  input  logic [ECI_W-1:0]        eci,
  input  logic [COUNTER_SIZE-1:0] total_cycles,
  input  logic [COUNTER_SIZE-1:0] recv_wait_cycles,
  input  logic [COUNTER_SIZE-1:0] total_ed_cycles,
  input  logic [COUNTER_SIZE-1:0] crf_total_cycles,
  input  logic [COUNTER_SIZE-1:0] crp_total_cycles,
  input  logic                    retvalS,
  output logic                    validS,
  output logic                    opcodeS,
  output logic [TAG_LEN-1:0]      addrS,
  output logic                    busy,
  output logic                    done,
  output logic [LOG_STR_LEN:0]    sym_index
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_COMM, S_SYNC, S_DONE} state_e;

  localparam int TGT_W   = 32;
  localparam int SYM_MAX = (1 << BPS) - 1;

  localparam logic [COUNTER_SIZE-1:0] CNT_ONE  = COUNTER_SIZE'(1);
  localparam logic [COUNTER_SIZE:0]   WCNT_ONE = (COUNTER_SIZE + 1)'(1);
  localparam logic [ECI_W-1:0]        ECI_ONE  = ECI_W'(1);
  localparam logic [TAG_LEN-1:0]      TAG_ONE  = TAG_LEN'(1);
  localparam logic [LOG_STR_LEN:0]    IDX_STEP = (LOG_STR_LEN + 1)'(BPS);

  state_e                  state_q, state_d;
  logic [COUNTER_SIZE:0]   wcnt_q;
  logic [COUNTER_SIZE-1:0] count_q, ed_count_q;
  logic [TAG_LEN-1:0]      issued_q;
  logic [ECI_W-1:0]        eci_cnt_q;
  logic [LOG_STR_LEN:0]    sym_index_q;

  logic [STR_LEN+BPS-1:0]  msg_pad;
  logic [BPS-1:0]          sym;
  logic [COUNTER_SIZE:0]   wait_lim;
  logic [COUNTER_SIZE-1:0] win_cnt;
  logic                    win_last;
  logic                    last_sym;
  logic                    eci_hit;
  logic [TGT_W-1:0]        tgt_comm, tgt_sync, target;
  logic                    req;
  logic                    hs;

  // Zero padding above the message makes bit positions past STR_LEN read as 0.
  assign msg_pad  = {{BPS{1'b0}}, string_i};
  assign sym      = msg_pad[sym_index_q +: BPS];
  assign wait_lim = {1'b0, crf_total_cycles} + {1'b0, crp_total_cycles} + WCNT_ONE;

  assign win_cnt  = (state_q == S_SYNC) ? ed_count_q : count_q;
  assign win_last = (state_q == S_SYNC) ? (ed_count_q == total_ed_cycles - CNT_ONE)
                                        : (count_q == total_cycles - CNT_ONE);
  assign last_sym = (32'(sym_index_q) + 32'(BPS)) >= 32'(STR_LEN);
  assign eci_hit  = (eci != '0) && (eci_cnt_q == eci - ECI_ONE);

  assign tgt_comm = TGT_W'(sym) * TGT_W'(BLK_PER_LVL);

`ifdef SENDER_PARITY_EN
  logic [BPS-1:0] par_acc_q, par_tgt_q;
  assign tgt_sync = TGT_W'(par_tgt_q) * TGT_W'(BLK_PER_LVL);
`else
  assign tgt_sync = TGT_W'(SYM_MAX * BLK_PER_LVL);
`endif

  assign target = (state_q == S_SYNC) ? tgt_sync : tgt_comm;

  // Request is a pure decode of registered state, so the cutoff removes it on
  // the very edge the window counter reaches recv_wait_cycles-1.
  assign req = ((state_q == S_COMM) || (state_q == S_SYNC))
            && (TGT_W'(issued_q) < target)
            && (win_cnt < recv_wait_cycles - CNT_ONE);
  assign hs  = req && retvalS;

  // State register.
  // NOTE: every piece of state is reset asynchronously so validS and addrS fall
  // the moment rst_n drops, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d is given a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (input_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (!input_ready)           state_d = S_IDLE;
        else if (wcnt_q == wait_lim) state_d = S_COMM;
      end
      S_COMM: begin
        if (!input_ready)  state_d = S_IDLE;
        else if (win_last) begin
          if (last_sym)     state_d = S_DONE;
          else if (eci_hit) state_d = S_SYNC;
        end
      end
      S_SYNC: begin
        if (!input_ready)  state_d = S_IDLE;
        else if (win_last) state_d = S_COMM;
      end
      S_DONE: if (!input_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: window counters, issued tag, symbol pointer.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q      <= '0;
      count_q     <= '0;
      ed_count_q  <= '0;
      issued_q    <= '0;
      eci_cnt_q   <= '0;
      sym_index_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (input_ready) sym_index_q <= {1'b0, eos};
          wcnt_q     <= '0;
          count_q    <= '0;
          ed_count_q <= '0;
          issued_q   <= '0;
          eci_cnt_q  <= '0;
        end
        S_WAIT: wcnt_q <= wcnt_q + WCNT_ONE;
        S_COMM: begin
          if (win_last) begin
            count_q     <= '0;
            issued_q    <= '0;
            sym_index_q <= sym_index_q + IDX_STEP;
            eci_cnt_q   <= eci_hit ? '0 : eci_cnt_q + ECI_ONE;
          end else begin
            count_q <= count_q + CNT_ONE;
            if (hs) issued_q <= issued_q + TAG_ONE;
          end
        end
        S_SYNC: begin
          if (win_last) begin
            ed_count_q <= '0;
            count_q    <= '0;
            issued_q   <= '0;
          end else begin
            ed_count_q <= ed_count_q + CNT_ONE;
            if (hs) issued_q <= issued_q + TAG_ONE;
          end
        end
        default: ;
      endcase
      // Abort: leaving for IDLE drops any pending request and clears counters.
      if (state_d == S_IDLE) begin
        wcnt_q     <= '0;
        count_q    <= '0;
        ed_count_q <= '0;
        issued_q   <= '0;
        eci_cnt_q  <= '0;
      end
    end
  end

`ifdef SENDER_PARITY_EN
  // XOR of symbols since the last sync; snapshotted into par_tgt_q on SYNC entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_acc_q <= '0;
      par_tgt_q <= '0;
    end else if (state_q == S_IDLE) begin
      par_acc_q <= '0;
    end else if (state_q == S_COMM && win_last && input_ready) begin
      if (state_d == S_SYNC) begin
        par_tgt_q <= par_acc_q ^ sym;
        par_acc_q <= '0;
      end else begin
        par_acc_q <= par_acc_q ^ sym;
      end
    end
  end
`endif

  // Outputs.
  always_comb begin
    validS    = req;
    opcodeS   = req;
    addrS     = issued_q;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    sym_index = sym_index_q;
  end

endmodule

// File: tb/tb_sender_multibit.sv
// Scoreboard bench for sender_multibit: expected tags are queued per symbol and
// popped on every validS/retvalS handshake.
module tb_sender_multibit;

  localparam int STR_LEN      = 64;
  localparam int LOG_STR_LEN  = 6;
  localparam int BPS          = 2;
  localparam int BLK_PER_LVL  = 4;
  localparam int TAG_LEN      = 8;
  localparam int COUNTER_SIZE = 16;
  localparam int ECI_W        = 6;
  localparam int WIN          = 64;
  localparam int ED_WIN       = 32;
  localparam int WAIT_LAT     = 17;  // crf=10, crp=5: COMM entered on edge 17

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    input_ready;
  logic [STR_LEN-1:0]      msg;
  logic [LOG_STR_LEN-1:0]  eos;
  logic [ECI_W-1:0]        eci;
  logic [COUNTER_SIZE-1:0] total_cycles, recv_wait_cycles, total_ed_cycles;
  logic [COUNTER_SIZE-1:0] crf_total_cycles, crp_total_cycles;
  logic                    retvalS;
  logic                    validS, opcodeS, busy, done;
  logic [TAG_LEN-1:0]      addrS;
  logic [LOG_STR_LEN:0]    sym_index;

  sender_multibit #(
    .STR_LEN(STR_LEN), .LOG_STR_LEN(LOG_STR_LEN), .BPS(BPS), .BLK_PER_LVL(BLK_PER_LVL),
    .TAG_LEN(TAG_LEN), .COUNTER_SIZE(COUNTER_SIZE), .ECI_W(ECI_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .input_ready(input_ready), .string_i(msg), .eos(eos),
    .eci(eci), .total_cycles(total_cycles), .recv_wait_cycles(recv_wait_cycles),
    .total_ed_cycles(total_ed_cycles), .crf_total_cycles(crf_total_cycles),
    .crp_total_cycles(crp_total_cycles), .retvalS(retvalS), .validS(validS),
    .opcodeS(opcodeS), .addrS(addrS), .busy(busy), .done(done), .sym_index(sym_index)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int sb_q[$];
  int mode      = 0;   // 0: ack always, 1: ack every third cycle, 2: never ack
  bit sb_en     = 1'b1;
  int cyc       = 0;
  int start_cyc = 0;
  int valid_cnt = 0;
  int hs_cnt    = 0;
  int addr_max  = 0;
  int last_hs   = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: drives retvalS and scores handshakes 1 time unit after each edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      case (mode)
        0:       retvalS = 1'b1;
        1:       retvalS = (cyc % 3 == 0);
        default: retvalS = 1'b0;
      endcase
      if (validS || opcodeS) check("opcode", int'(opcodeS), int'(validS));
      if (validS) begin
        valid_cnt++;
        if (int'(addrS) > addr_max) addr_max = int'(addrS);
      end
      if (sb_en && validS && retvalS) begin
        hs_cnt++;
        if (sb_q.size() == 0) check("sb_underflow", int'(addrS), -1);
        else                  check("tag", int'(addrS), sb_q.pop_front());
        if (mode == 0 && addrS != 0) check("gap", cyc - last_hs, 1);
        last_hs = cyc;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_sym(input int s);
    for (int i = 0; i < s * BLK_PER_LVL; i++) sb_q.push_back(i);
  endtask

  task automatic start_msg();
    input_ready = 1'b1;
    start_cyc   = cyc;
  endtask

  // Latency is the index of the clock edge (0 = first edge with input_ready high).
  task automatic wait_done(input int limit, output int lat);
    lat = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - start_cyc - 1;
        break;
      end
    end
    if (lat < 0) check("timeout_done", 0, 1);
  endtask

  task automatic finish_msg();
    input_ready = 1'b0;
    cycles(2);
  endtask

  int lat;
  int acc;
  int sync_lvl;
  int syms[6] = '{1, 3, 0, 2, 1, 3};

  initial begin
    rst_n = 1'b0; input_ready = 1'b0; msg = '0; eos = '0; eci = '0; retvalS = 1'b0;
    total_cycles = 16'(WIN); recv_wait_cycles = 16'd40; total_ed_cycles = 16'(ED_WIN);
    crf_total_cycles = 16'd10; crp_total_cycles = 16'd5;
    #3;
    check("rst_valid", int'(validS), 0);
    check("rst_opcode", int'(opcodeS), 0);
    check("rst_addr", int'(addrS), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_sym_index", int'(sym_index), 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(2);

    // A: symbols 11, 01, 00 at full acknowledge rate; WAIT latency.
    msg = '0; msg[59:58] = 2'b11; msg[61:60] = 2'b01; eos = 6'd58;
    mode = 0; hs_cnt = 0;
    push_sym(3); push_sym(1); push_sym(0);
    start_msg();
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (validS) begin lat = cyc - start_cyc - 1; break; end
    end
    check("first_valid_lat", lat, WAIT_LAT);
    wait_done(600, lat);
    check("done_lat_a", lat, WAIT_LAT + 3 * WIN);
    check("sym_index_end", int'(sym_index), 64);
    check("hs_a", hs_cnt, 16);
    check("sb_empty_a", sb_q.size(), 0);
    check("busy_done", int'(busy), 1);
    check("valid_in_done", int'(validS), 0);
    finish_msg();
    check("done_clear", int'(done), 0);
    check("busy_idle", int'(busy), 0);

    // B: symbol 01 with acknowledge every third cycle.
    msg = '0; msg[63:62] = 2'b01; eos = 6'd62;
    mode = 1; hs_cnt = 0;
    push_sym(1);
    start_msg();
    wait_done(400, lat);
    check("hs_b", hs_cnt, 4);
    check("sb_empty_b", sb_q.size(), 0);
    finish_msg();

    // C: symbols 11, 11 never acknowledged; cutoff at count 39 each window.
    msg = '0; msg[61:60] = 2'b11; msg[63:62] = 2'b11; eos = 6'd60;
    mode = 2; hs_cnt = 0; valid_cnt = 0; addr_max = 0;
    start_msg();
    wait_done(400, lat);
    check("valid_cycles_c", valid_cnt, 2 * 39);
    check("addr_held_c", addr_max, 0);
    check("hs_c", hs_cnt, 0);
    finish_msg();

    // D: eci=2, six symbols; sync after symbols 2 and 4, none after 6.
    msg = '0; eos = 6'd52; eci = 6'd2; mode = 0; hs_cnt = 0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      msg[52 + 2 * i +: 2] = 2'(syms[i]);
      push_sym(syms[i]);
      acc = acc ^ syms[i];
      if (i == 1 || i == 3) begin
`ifdef SENDER_PARITY_EN
        sync_lvl = acc;
`else
        sync_lvl = 3;
`endif
        push_sym(sync_lvl);
        acc = 0;
      end
    end
    start_msg();
    wait_done(900, lat);
    check("done_lat_d", lat, WAIT_LAT + 6 * WIN + 2 * ED_WIN);
    check("sb_empty_d", sb_q.size(), 0);
    check("sym_index_d", int'(sym_index), 64);
    finish_msg();
    eci = '0;

    // E: input_ready dropped during WAIT.
    msg = '1; eos = '0; valid_cnt = 0;
    start_msg();
    cycles(5);
    input_ready = 1'b0;
    cycles(2);
    check("abort_busy", int'(busy), 0);
    cycles(20);
    check("abort_valid", valid_cnt, 0);

    // F: asynchronous reset mid-COMM while a request is outstanding.
    mode = 1; sb_en = 1'b0; lat = -1;
    start_msg();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (validS && addrS == 8'd2) begin lat = i; break; end
    end
    check("reach_tag2", int'(lat >= 0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", int'(validS), 0);
    check("async_addr", int'(addrS), 0);
    check("async_busy", int'(busy), 0);
    input_ready = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    check("post_rst_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
